// File: rtl/periph_bus_responder_pkg.sv
// Shared constants for the peripheral bus responder: register offsets, TCON bit
// indices, default window base, and the write-select payload.
package periph_bus_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned SW_W   = 8;
  localparam int unsigned DIGI_W = 12;
  localparam int unsigned TCON_W = 3;

  localparam logic [OFF_W-1:0] OFF_TH      = 6'h00;
  localparam logic [OFF_W-1:0] OFF_TL      = 6'h04;
  localparam logic [OFF_W-1:0] OFF_TCON    = 6'h08;
  localparam logic [OFF_W-1:0] OFF_LED     = 6'h0C;
  localparam logic [OFF_W-1:0] OFF_SWITCH  = 6'h10;
  localparam logic [OFF_W-1:0] OFF_DIGI    = 6'h14;
  localparam logic [OFF_W-1:0] OFF_SYSTICK = 6'h18;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  // One-hot write enables produced by the address decoder.
  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
    logic led;
    logic digi;
  } wr_sel_t;

endpackage

// File: rtl/periph_bus_responder_timer.sv
// Timer core: TH reload value, TL up-counter and TCON control/status, with CPU
// writes taking priority over the counter's own updates.
module periph_timer
  import periph_bus_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              th_we,
  input  logic              tl_we,
  input  logic              tcon_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] th,
  output logic [DATA_W-1:0] tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irq
);

  logic              ovf_c;
  logic [DATA_W-1:0] tl_next_c;
  logic [TCON_W-1:0] tcon_next_c;

  assign ovf_c = tcon[TCON_EN] && (tl == {DATA_W{1'b1}});

  // Overflow is judged on the current TL, so the status bit still sets when
  // the CPU overwrites TL in the overflow cycle.
  always_comb begin
    tl_next_c   = tl;
    tcon_next_c = tcon;
    if (tl_we) begin
      tl_next_c = wdata;
    end else if (ovf_c) begin
      tl_next_c = th;
    end else if (tcon[TCON_EN]) begin
      tl_next_c = tl + DATA_W'(1);
    end
    if (tcon_we) begin
      tcon_next_c = wdata[TCON_W-1:0];
    end else if (ovf_c && tcon[TCON_IE]) begin
      tcon_next_c[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (th_we) th <= wdata;
      tl   <= tl_next_c;
      tcon <= tcon_next_c;
    end
  end

  assign irq = tcon[TCON_IS];

endmodule

// File: rtl/periph_bus_responder.sv
// Peripheral window responder: decode, LED/DIGI/switch registers, timer, and a
// zero-latency read mux. Optional free-running counter under PERIPH_SYSTICK_EN.
module periph_bus_responder
  import periph_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  logic [OFF_W-1:0]  off;
  logic [1:0]        unused_addr_lsb;
  wr_sel_t           wsel;
  logic [DATA_W-1:0] th;
  logic [DATA_W-1:0] tl;
  logic [TCON_W-1:0] tcon;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;

  assign unused_addr_lsb = addr[1:0];
  assign off = {addr[OFF_W-1:2], 2'b00};
  assign hit = (addr[31:OFF_W] == BASE_ADDR[31:OFF_W]);

  // Write decode; RO and unmapped offsets produce no enable.
  always_comb begin
    wsel = '0;
    if (wr && hit) begin
      case (off)
        OFF_TH:   wsel.th   = 1'b1;
        OFF_TL:   wsel.tl   = 1'b1;
        OFF_TCON: wsel.tcon = 1'b1;
        OFF_LED:  wsel.led  = 1'b1;
        OFF_DIGI: wsel.digi = 1'b1;
        default:  ;
      endcase
    end
  end

  periph_timer u_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .th_we   (wsel.th),
    .tl_we   (wsel.tl),
    .tcon_we (wsel.tcon),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irqout)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      led     <= '0;
      digi    <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (wsel.led)  led  <= wdata[LED_W-1:0];
      if (wsel.digi) digi <= wdata[DIGI_W-1:0];
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [DATA_W-1:0] systick;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      systick <= '0;
    end else begin
      systick <= systick + DATA_W'(1);
    end
  end
`endif

  // Read mux reflects pre-write state, so rd+wr in one cycle returns the old value.
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (off)
        OFF_TH:      rdata = th;
        OFF_TL:      rdata = tl;
        OFF_TCON:    rdata = DATA_W'(tcon);
        OFF_LED:     rdata = DATA_W'(led);
        OFF_SWITCH:  rdata = DATA_W'(sw_sync);
        OFF_DIGI:    rdata = DATA_W'(digi);
`ifdef PERIPH_SYSTICK_EN
        OFF_SYSTICK: rdata = systick;
`endif
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_responder.sv
// Self-checking bench for periph_bus_responder: vector table plus hand-written
// timer, switch, reset and (if PERIPH_SYSTICK_EN) systick sequences.
module tb_periph_bus_responder;

  localparam logic [31:0] B = 32'h4000_0000;

  typedef enum int {S_RDATA, S_HIT, S_LED, S_DIGI, S_IRQ} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    sel_e        sel;
    logic [31:0] val;
    logic        exp_hit;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  periph_bus_responder dut (
    .clk     (clk),
    .reset_b (reset_b),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hit     (hit),
    .switch  (switch),
    .led     (led),
    .digi    (digi),
    .irqout  (irqout)
  );

  always #5 clk = ~clk;

  // Scoreboard: every expectation queued during a cycle is checked at its negedge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        S_RDATA: act = rdata;
        S_HIT:   act = 32'(hit);
        S_LED:   act = 32'(led);
        S_DIGI:  act = 32'(digi);
        default: act = 32'(irqout);
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
  endtask

  task automatic expect_v(input string nm, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.sel = s; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    step();
    drive(1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] v);
    drive(1'b1, 1'b0, a, 32'h0);
    expect_v(nm, S_RDATA, v);
    step();
    drive(1'b0, 1'b0, a, 32'h0);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input sel_e s, input logic [31:0] v,
                              input logic h, input string nm);
    vec_t t;
    t.rd = r; t.wr = w; t.addr = a; t.wdata = d;
    t.sel = s; t.val = v; t.exp_hit = h; t.name = nm;
    return t;
  endfunction

  initial begin
    reset_b = 1'b0;
    switch  = 8'h00;
    drive(1'b0, 1'b0, B, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(1'b1, 1'b0, B + 32'h04, 32'h0);
    expect_v("rst_rdata_tl", S_RDATA, 32'h0);
    expect_v("rst_led", S_LED, 32'h0);
    expect_v("rst_digi", S_DIGI, 32'h0);
    expect_v("rst_irq", S_IRQ, 32'h0);
    step();
    drive(1'b0, 1'b0, B, 32'h0);
    reset_b = 1'b1;
    step();

    // Register access and decode vectors (timer disabled, so TL holds)
    tbl.push_back(mk(0, 1, B + 32'h00, 32'h1234_5678, S_HIT,   32'h1,         1, "wr_th"));
    tbl.push_back(mk(1, 0, B + 32'h00, 32'h0,         S_RDATA, 32'h1234_5678, 1, "rd_th"));
    tbl.push_back(mk(0, 1, B + 32'h04, 32'hCAFE_0001, S_HIT,   32'h1,         1, "wr_tl"));
    tbl.push_back(mk(1, 0, B + 32'h04, 32'h0,         S_RDATA, 32'hCAFE_0001, 1, "rd_tl_held"));
    tbl.push_back(mk(0, 1, B + 32'h0C, 32'hFFFF_FFA5, S_LED,   32'h0,         1, "led_before_edge"));
    tbl.push_back(mk(1, 0, B + 32'h0C, 32'h0,         S_RDATA, 32'h0000_00A5, 1, "rd_led_zext"));
    tbl.push_back(mk(0, 0, B + 32'h0C, 32'h0,         S_LED,   32'h0000_00A5, 1, "led_out"));
    tbl.push_back(mk(0, 1, B + 32'h14, 32'h0FFF_FF3C, S_HIT,   32'h1,         1, "wr_digi"));
    tbl.push_back(mk(0, 0, B + 32'h14, 32'h0,         S_DIGI,  32'h0000_0F3C, 1, "digi_out"));
    tbl.push_back(mk(1, 0, B + 32'h14, 32'h0,         S_RDATA, 32'h0000_0F3C, 1, "rd_digi"));
    tbl.push_back(mk(0, 1, B + 32'h10, 32'hFFFF_FFFF, S_HIT,   32'h1,         1, "wr_switch_ro"));
    tbl.push_back(mk(1, 0, B + 32'h10, 32'h0,         S_RDATA, 32'h0,         1, "rd_switch_unchanged"));
    tbl.push_back(mk(1, 0, B + 32'h20, 32'h0,         S_RDATA, 32'h0,         1, "rd_unmapped_20"));
    tbl.push_back(mk(1, 0, B + 32'h1C, 32'h0,         S_RDATA, 32'h0,         1, "rd_unmapped_1c"));
    tbl.push_back(mk(1, 0, 32'h0000_0010, 32'h0,      S_RDATA, 32'h0,         0, "rd_outside"));
    tbl.push_back(mk(1, 0, B + 32'h40, 32'h0,         S_RDATA, 32'h0,         0, "rd_past_window"));
    tbl.push_back(mk(0, 0, B + 32'h00, 32'h0,         S_RDATA, 32'h0,         1, "no_rd_zero"));
    tbl.push_back(mk(1, 0, B + 32'h08, 32'h0,         S_RDATA, 32'h0,         1, "rd_tcon_rst"));
    tbl.push_back(mk(1, 1, B + 32'h00, 32'hDEAD_BEEF, S_RDATA, 32'h1234_5678, 1, "rdwr_pre_value"));
    tbl.push_back(mk(1, 0, B + 32'h03, 32'h0,         S_RDATA, 32'hDEAD_BEEF, 1, "rd_th_lsb_ignored"));
    tbl.push_back(mk(0, 1, B + 32'h08, 32'hFFFF_FFFC, S_IRQ,   32'h0,         1, "wr_tcon_is"));
    tbl.push_back(mk(1, 0, B + 32'h08, 32'h0,         S_RDATA, 32'h0000_0004, 1, "rd_tcon_is"));
    tbl.push_back(mk(0, 1, B + 32'h08, 32'h0,         S_IRQ,   32'h1,         1, "irq_by_write"));
    tbl.push_back(mk(0, 0, B + 32'h08, 32'h0,         S_IRQ,   32'h0,         1, "irq_cleared"));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      expect_v(tbl[i].name, tbl[i].sel, tbl[i].val);
      expect_v({tbl[i].name, "_hit"}, S_HIT, 32'(tbl[i].exp_hit));
      step();
    end
    drive(1'b0, 1'b0, B, 32'h0);

    // Switch synchronizer latency
    switch = 8'h5A;
    rd_chk("sw_lat0", B + 32'h10, 32'h0);
    rd_chk("sw_lat1", B + 32'h10, 32'h0);
    rd_chk("sw_lat2", B + 32'h10, 32'h0000_005A);

    // Timer overflow and reload
    wr_reg(B + 32'h00, 32'hFFFF_FFF0);
    wr_reg(B + 32'h04, 32'hFFFF_FFFD);
    wr_reg(B + 32'h08, 32'h0000_0003);
    rd_chk("tl_fffd", B + 32'h04, 32'hFFFF_FFFD);
    rd_chk("tl_fffe", B + 32'h04, 32'hFFFF_FFFE);
    expect_v("irq_pre_ovf", S_IRQ, 32'h0);
    rd_chk("tl_ffff", B + 32'h04, 32'hFFFF_FFFF);
    expect_v("irq_after_reload", S_IRQ, 32'h1);
    rd_chk("tl_reload", B + 32'h04, 32'hFFFF_FFF0);
    expect_v("irq_held", S_IRQ, 32'h1);
    wr_reg(B + 32'h08, 32'h0000_0003);
    expect_v("irq_clear_write", S_IRQ, 32'h0);
    rd_chk("tl_after_clear", B + 32'h04, 32'hFFFF_FFF2);

    // CPU write to TL in the overflow cycle
    wr_reg(B + 32'h04, 32'hFFFF_FFFE);
    expect_v("irq_pri_pre", S_IRQ, 32'h0);
    rd_chk("tl_pri_fffe", B + 32'h04, 32'hFFFF_FFFE);
    drive(1'b1, 1'b1, B + 32'h04, 32'h0000_1234);
    expect_v("tl_pri_ovf_cycle", S_RDATA, 32'hFFFF_FFFF);
    step();
    expect_v("irq_pri", S_IRQ, 32'h1);
    rd_chk("tl_pri_cpu_wins", B + 32'h04, 32'h0000_1234);
    rd_chk("tl_pri_counts", B + 32'h04, 32'h0000_1235);

    // TH = all ones overflows every cycle; IE=0 keeps the status clear
    wr_reg(B + 32'h08, 32'h0);
    wr_reg(B + 32'h00, 32'hFFFF_FFFF);
    wr_reg(B + 32'h04, 32'hFFFF_FFFF);
    wr_reg(B + 32'h08, 32'h0000_0001);
    rd_chk("th_max_a", B + 32'h04, 32'hFFFF_FFFF);
    rd_chk("th_max_b", B + 32'h04, 32'hFFFF_FFFF);
    expect_v("th_max_noirq", S_IRQ, 32'h0);
    rd_chk("th_max_c", B + 32'h04, 32'hFFFF_FFFF);

    // Reset in the middle of a running count
    wr_reg(B + 32'h00, 32'h0000_0100);
    wr_reg(B + 32'h08, 32'h0000_0003);
    wr_reg(B + 32'h04, 32'hFFFF_FFFF);
    reset_b = 1'b0;
    expect_v("mid_rst_led", S_LED, 32'h0);
    expect_v("mid_rst_digi", S_DIGI, 32'h0);
    expect_v("mid_rst_irq", S_IRQ, 32'h0);
    for (int o = 0; o <= 32'h18; o += 4) begin
      rd_chk($sformatf("mid_rst_rd_%02h", o), B + 32'(o), 32'h0);
    end
    reset_b = 1'b1;
    step();
    step();
    rd_chk("post_rst_switch", B + 32'h10, 32'h0000_005A);
    rd_chk("post_rst_tl_held", B + 32'h04, 32'h0);
    rd_chk("post_rst_th", B + 32'h00, 32'h0);

`ifdef PERIPH_SYSTICK_EN
    begin
      logic [31:0] t0;
      logic [31:0] t1;
      drive(1'b1, 1'b0, B + 32'h18, 32'h0);
      @(negedge clk);
      t0 = rdata;
      repeat (7) @(negedge clk);
      t1 = rdata;
      n_cmp++;
      if (t1 - t0 !== 32'd7) begin
        n_bad++;
        $display("FAIL systick_delta: got %0d, expected 7", t1 - t0);
      end
      #1;
      drive(1'b0, 1'b0, B, 32'h0);
      step();
    end
`else
    rd_chk("systick_off_a", B + 32'h18, 32'h0);
    step();
    rd_chk("systick_off_b", B + 32'h18, 32'h0);
`endif

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
